// File: rtl/usb_system_pio_pkg.sv
// Shared register map and edge-mode encodings for the usb_system input PIO.
package usb_system_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Debounce counter must hold 0..D; a bypassed filter still needs a legal width.
  function automatic int counter_width(input int d);
    return (d < 1) ? 1 : $clog2(d + 1);
  endfunction

endpackage

// File: rtl/usb_system_pio_debounce.sv
// One input bit: two-flop synchroniser followed by an optional stability filter.
module usb_system_pio_debounce
  import usb_system_pio_pkg::*;
#(
  parameter int D = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic stable
);

  logic s1;
  logic s2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  generate
    if (D == 0) begin : g_bypass
      assign stable = s2;
    end else begin : g_filter
      localparam int CW = counter_width(D);

      logic [CW-1:0] count;
      logic          stable_q;

      // A change is accepted only after s2 has differed from stable for D cycles in a row.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          count    <= '0;
          stable_q <= 1'b0;
        end else if (s2 == stable_q) begin
          count <= '0;
        end else if (count == CW'(D - 1)) begin
          stable_q <= s2;
          count    <= '0;
        end else begin
          count <= count + CW'(1);
        end
      end

      assign stable = stable_q;
    end
  endgenerate

endmodule

// File: rtl/usb_system_pio_capture.sv
// Avalon-MM input PIO: synchronised/debounced inputs, edge capture with
// write-1-to-clear, interrupt mask and a level IRQ.
module usb_system_pio_capture
  import usb_system_pio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clear_bits;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [31:0]      rd_mux;
  logic             wr_en;

  genvar b;
  generate
    for (b = 0; b < WIDTH; b++) begin : g_bit
      usb_system_pio_debounce #(.D(DEBOUNCE_CYCLES)) u_debounce (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (in_port[b]),
        .stable (stable[b])
      );
    end

    if (WIDTH < 32) begin : g_unused_hi
      logic unused_writedata_hi;
      assign unused_writedata_hi = ^writedata[31:WIDTH];
    end
  endgenerate

  assign wr_en = chipselect && !write_n;

  always_comb begin
    edge_det = stable & ~prev;
    if (EDGE_TYPE == EDGE_FALLING) begin
      edge_det = ~stable & prev;
    end else if (EDGE_TYPE == EDGE_ANY) begin
      edge_det = stable ^ prev;
    end
  end

  always_comb begin
    clear_bits = '0;
    if (wr_en && (address == PIO_ADDR_EDGECAP)) begin
      clear_bits = writedata[WIDTH-1:0];
    end
  end

  // A new edge in the same cycle as a clear keeps its bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev        <= '0;
      edgecapture <= '0;
      irqmask     <= '0;
    end else begin
      prev        <= stable;
      edgecapture <= (edgecapture & ~clear_bits) | edge_det;
      if (wr_en && (address == PIO_ADDR_IRQMASK)) begin
        irqmask <= writedata[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      PIO_ADDR_DATA:    rd_mux[WIDTH-1:0] = stable;
      PIO_ADDR_RSVD:    rd_mux = '0;
      PIO_ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
      PIO_ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecapture;
      default:          rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

  assign irq = |(edgecapture & irqmask);

endmodule

// File: doc/usb_system_pio_capture.md
# usb_system_pio_capture

Parametrised Avalon-MM input PIO for the usb_system Qsys design, successor to the fixed 8-bit switch input port. Adds two-flop synchronisation, optional per-bit debounce, per-bit edge capture with write-1-to-clear, an interrupt mask and a level IRQ. It sits on the system interconnect as a slave, alongside the existing PIO ports, feeding switches and buttons to the Nios II.

## Interface
- `WIDTH`, 8: input port width, 1..32.
- `DEBOUNCE_CYCLES`, 0: cycles a changed synchronised bit must stay stable before it is accepted. 0 means bypass.
- `EDGE_TYPE`, 0: capture on 0 = rising, 1 = falling, 2 = any edge.
- `clk`, in, 1: system clock.
- `reset_n`, in, 1: one clock; reset is asynchronous and active-low.
- `address`, in, 2: register select.
- `chipselect`, in, 1: slave select.
- `write_n`, in, 1: active-low write strobe.
- `writedata`, in, 32: write data. Bits above WIDTH are ignored.
- `in_port`, in, WIDTH: asynchronous external inputs.
- `readdata`, out, 32: registered read data. Bits above WIDTH always read 0.
- `irq`, out, 1: level interrupt, `|(edgecapture & irqmask)`.

## Operation
- Register map:
  - 0 = data (RO, debounced value).
  - 1 = reserved (reads 0, writes ignored).
  - 2 = irqmask (RW).
  - 3 = edgecapture (read; writing 1 to a bit clears that bit).
- A write occurs when `chipselect && !write_n`. Writes to address 0 are ignored.
- Read path: `readdata` is reloaded every clock from the mux selected by `address`. It does not depend on `chipselect` (read latency 1, no wait states).
- Sync: `in_port` passes through two flops (s1, s2) per bit.
- Debounce (DEBOUNCE_CYCLES = D ≥ 1), per bit:
  - The counter resets to 0 whenever s2 equals stable.
  - Otherwise it increments.
  - When the counter equals D−1 and s2 still differs from stable, `stable <= s2` and the counter resets to 0.
  - Counter width is clog2(D+1).
  - With D = 0, stable is s2 directly.
- Edge detect: `prev <= stable` every cycle.
  - Rising edge = stable & ~prev.
  - Falling edge = ~stable & prev.
  - Any edge = either.
- edgecapture bit: set on a detected edge. Cleared by a write-1 to address 3.
  - Set and clear in the same cycle: set wins.
- irq: combinational AND/OR of registered bits only (glitch-free).
- Reset values: s1, s2, stable, prev, counters, irqmask, edgecapture, `readdata` = 0; `irq` = 0.
  - An input held high through reset is seen as a rising edge after release. This is intended.
- Reset asserted mid-debounce or mid-capture: all state clears immediately and asynchronously. No pending edge survives.

## Timing
- `in_port` bit change first sampled at clock edge k:
  - s2 updates at k+1.
  - stable updates at k+1+D.
  - edgecapture and `irq` assert after edge k+2+D.
- A glitch shorter than D cycles at s2 never reaches stable: counter reset, no capture.
- Read: `address` sampled at edge n, `readdata` valid after edge n. The master samples it at edge n+1.
- Write-1-to-clear at edge n: the bit reads 0 from a read addressed at n+1. `irq` deasserts after edge n unless another edge is set at the same edge.
- irqmask write at edge n affects `irq` after edge n.

## Structure
- Package `usb_system_pio_pkg`:
  - address constants `PIO_ADDR_DATA`/`RSVD`/`IRQMASK`/`EDGECAP`;
  - `EDGE_RISING`/`FALLING`/`ANY` encodings.
- Sub-module `usb_system_pio_debounce`: one bit, holds sync flops, counter and stable. Parameter D. Instantiated WIDTH times in a generate loop.
- The top level holds prev, edge logic, registers, read mux and irq.

## Test plan
- Reset, then reads of addresses 0–3 → readdata = 0 each, `irq` = 0. Address 1 after writing 0xFFFFFFFF → still 0.
- WIDTH=8, D=0, EDGE=0: `in_port` 0x00→0x5A at edge k → data reads 0x5A. edgecapture = 0x5A after edge k+2. With irqmask = 0x02, `irq` = 1 after edge k+2.
- D=4: 3-cycle pulse on bit 0 → data and edgecapture unchanged. 4-cycle stable change → stable updates exactly at edge k+5.
- EDGE=1 and EDGE=2: toggle bit 3 high then low → falling mode captures only the fall; any mode captures both.
- Write 0x01 to address 3 in the same cycle a new edge arrives on bit 0 → bit 0 stays 1. Write 0x01 alone → bit 0 clears and `irq` drops the next cycle.
- Assert reset_n low mid-debounce with edgecapture = 0xFF → all registers and `irq` go to 0 asynchronously. No capture after release unless an input is high.
